// File: rtl/packet_builder_pkg.sv
// Shared constants, FSM state type and payload pattern helper for the AXIS frame builder.
package packet_builder_pkg;

    localparam int ETH_HDR_BYTES = 14;
    localparam int MAC_WIDTH     = 48;
    localparam int ETYPE_WIDTH   = 16;
    localparam int SEED_WIDTH    = 8;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_INCR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } state_t;

    // k_lo is the low byte of the frame offset; mod-256 arithmetic keeps it exact.
    function automatic logic [7:0] payload_byte(input logic [7:0] seed,
                                                input logic       mode,
                                                input logic [7:0] k_lo);
        logic [7:0] r;
        r = seed;
        case (mode)
            MODE_FILL: r = seed;
            MODE_INCR: r = seed + k_lo - 8'(ETH_HDR_BYTES);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axis_keep_mask.sv
// Turns a remaining-byte count into a tkeep vector: bit i is set while byte i is still inside the frame.
module axis_keep_mask #(
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = 14
) (
    input  logic [CNT_WIDTH-1:0]  remaining,
    output logic [KEEP_WIDTH-1:0] keep
);

    genvar gi;
    generate
        for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_keep
            assign keep[gi] = (remaining > CNT_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/packet_builder_axis.sv
// Command-driven Ethernet frame generator with an AXI4-Stream master output and full backpressure.
module packet_builder_axis
    import packet_builder_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 14,
    parameter int MIN_SIZE   = 60
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SIZE_WIDTH-1:0]     cmd_size,
    input  logic [MAC_WIDTH-1:0]      cmd_d_mac,
    input  logic [MAC_WIDTH-1:0]      cmd_s_mac,
    input  logic [ETYPE_WIDTH-1:0]    cmd_ethertype,
    input  logic [SEED_WIDTH-1:0]     cmd_seed,
    input  logic                      cmd_mode,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic [31:0]               frames_sent
);

    localparam int BYTES = DATA_WIDTH / 8;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   tdata_reg;
    logic [BYTES-1:0]        tkeep_reg;
    logic                    tvalid_reg;
    logic                    tlast_reg;
    logic [31:0]             frames_sent_reg;
    logic [SIZE_WIDTH-1:0]   size_reg;
    logic [SIZE_WIDTH-1:0]   off_reg;
    logic [SEED_WIDTH-1:0]   seed_reg;
    logic                    mode_reg;

    logic                    accept_last;
    logic                    load_first;
    logic                    load_en;
    logic [SIZE_WIDTH-1:0]   eff_size;
    logic [SIZE_WIDTH-1:0]   src_off;
    logic [SIZE_WIDTH-1:0]   src_size;
    logic [SIZE_WIDTH-1:0]   src_rem;
    logic [SEED_WIDTH-1:0]   src_seed;
    logic                    src_mode;
    logic                    src_last;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [BYTES-1:0]        beat_keep;

    assign accept_last = tvalid_reg & m_axis_tready & tlast_reg;
    assign cmd_ready   = (state_reg == ST_IDLE) | accept_last;
    // Whenever a command can be taken, the beat being built is a new frame's header beat.
    assign load_first  = cmd_ready;
    assign load_en     = load_first ? cmd_valid : (tvalid_reg & m_axis_tready);
    assign eff_size    = (cmd_size < SIZE_WIDTH'(MIN_SIZE)) ? SIZE_WIDTH'(MIN_SIZE) : cmd_size;

    always_comb begin
        src_off  = off_reg + SIZE_WIDTH'(BYTES);
        src_size = size_reg;
        src_seed = seed_reg;
        src_mode = mode_reg;
        if (load_first) begin
            src_off  = '0;
            src_size = eff_size;
            src_seed = cmd_seed;
            src_mode = cmd_mode;
        end
    end

    assign src_rem  = src_size - src_off;
    assign src_last = (src_rem <= SIZE_WIDTH'(BYTES));

    axis_keep_mask #(
        .KEEP_WIDTH (BYTES),
        .CNT_WIDTH  (SIZE_WIDTH)
    ) u_keep_mask (
        .remaining  (src_rem),
        .keep       (beat_keep)
    );

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_byte
            logic [7:0] pay_byte;
            logic [7:0] hdr_byte;
            assign pay_byte = payload_byte(src_seed, src_mode, src_off[7:0] + 8'(gi));
            if (gi < 6) begin : g_dmac
                assign hdr_byte = cmd_d_mac[8*gi +: 8];
            end else if (gi < 12) begin : g_smac
                assign hdr_byte = cmd_s_mac[8*(gi-6) +: 8];
            end else if (gi < ETH_HDR_BYTES) begin : g_etype
                assign hdr_byte = cmd_ethertype[8*(gi-12) +: 8];
            end else begin : g_pay
                assign hdr_byte = pay_byte;
            end
            assign beat_data[8*gi +: 8] = load_first ? hdr_byte : pay_byte;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            tdata_reg       <= '0;
            tkeep_reg       <= '0;
            tvalid_reg      <= 1'b0;
            tlast_reg       <= 1'b0;
            frames_sent_reg <= '0;
            size_reg        <= '0;
            off_reg         <= '0;
            seed_reg        <= '0;
            mode_reg        <= 1'b0;
        end else begin
            if (accept_last) begin
                frames_sent_reg <= frames_sent_reg + 32'd1;
            end
            if (load_en) begin
                tdata_reg  <= beat_data;
                tkeep_reg  <= beat_keep;
                tlast_reg  <= src_last;
                tvalid_reg <= 1'b1;
                off_reg    <= src_off;
                size_reg   <= src_size;
                seed_reg   <= src_seed;
                mode_reg   <= src_mode;
                state_reg  <= load_first ? ST_HEAD : ST_BODY;
            end else if (accept_last) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
                state_reg  <= ST_IDLE;
            end
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tkeep  = tkeep_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign busy          = tvalid_reg;
    assign frames_sent   = frames_sent_reg;

endmodule

// File: tb/tb_packet_builder_axis.sv
// Scoreboard bench for packet_builder_axis at DATA_WIDTH=128 (16 bytes per beat).
module tb_packet_builder_axis;

    localparam int DW   = 128;
    localparam int SW   = 14;
    localparam int MINS = 60;
    localparam int NB   = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [SW-1:0]  cmd_size;
    logic [47:0]    cmd_d_mac;
    logic [47:0]    cmd_s_mac;
    logic [15:0]    cmd_ethertype;
    logic [7:0]     cmd_seed;
    logic           cmd_mode;
    logic [DW-1:0]  m_axis_tdata;
    logic [NB-1:0]  m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           m_axis_tlast;
    logic           busy;
    logic [31:0]    frames_sent;

    packet_builder_axis #(
        .DATA_WIDTH (DW),
        .SIZE_WIDTH (SW),
        .MIN_SIZE   (MINS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_size      (cmd_size),
        .cmd_d_mac     (cmd_d_mac),
        .cmd_s_mac     (cmd_s_mac),
        .cmd_ethertype (cmd_ethertype),
        .cmd_seed      (cmd_seed),
        .cmd_mode      (cmd_mode),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frames_sent   (frames_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    beat_t          exp_q[$];
    beat_t          mon_beat;
    int             checks = 0;
    int             errors = 0;
    int             cycle = 0;
    int             beat_idx = 0;
    int             tlast_cycle = -100;
    int             head_gap = 0;
    int             n_sent = 0;
    bit             rand_ready = 1'b0;
    logic           stalled_prev = 1'b0;
    logic [144:0]   held;
    logic [DW-1:0]  cap_data [0:7];
    logic [NB-1:0]  cap_keep [0:7];

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, obs, req);
        end
    endtask

    function automatic logic [DW-1:0] model_beat(input logic [47:0] d, input logic [47:0] s,
                                                 input logic [15:0] et, input logic [7:0] seed,
                                                 input logic mode, input int b);
        logic [DW-1:0] r;
        logic [7:0]    v;
        int            k;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            k = b * NB + i;
            if (k < 6)       v = d[8*k +: 8];
            else if (k < 12) v = s[8*(k-6) +: 8];
            else if (k < 14) v = et[8*(k-12) +: 8];
            else if (mode)   v = seed + 8'(k - 14);
            else             v = seed;
            r[8*i +: 8] = v;
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] model_keep(input int s, input int b);
        int rem;
        rem = s - b * NB;
        if (rem >= NB) return '1;
        return NB'((32'd1 << rem) - 32'd1);
    endfunction

    // Output monitor: one line per accepted beat, compared against the scoreboard.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            beat_idx     = 0;
            stalled_prev = 1'b0;
        end else begin
            check("cmd_ready", cmd_ready, m_axis_tvalid ? (m_axis_tready & m_axis_tlast) : 1'b1);
            if (stalled_prev) begin
                check("stall_valid", m_axis_tvalid, 1'b1);
                check("stall_hold", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, held);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                $display("beat %0d data=%h keep=%h last=%0b", beat_idx, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    mon_beat = exp_q.pop_front();
                    check("tdata", m_axis_tdata, mon_beat.data);
                    check("tkeep", m_axis_tkeep, mon_beat.keep);
                    check("tlast", m_axis_tlast, mon_beat.last);
                end
                if (beat_idx < 8) begin
                    cap_data[beat_idx] = m_axis_tdata;
                    cap_keep[beat_idx] = m_axis_tkeep;
                end
                if (beat_idx == 0) head_gap = cycle - tlast_cycle;
                if (m_axis_tlast) begin
                    beat_idx    = 0;
                    tlast_cycle = cycle;
                end else begin
                    beat_idx++;
                end
            end
            stalled_prev = m_axis_tvalid && !m_axis_tready;
            held         = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_cmd(input int size, input logic mode, input logic [7:0] seed);
        logic [63:0] r1;
        logic [63:0] r2;
        beat_t       e;
        bit          ok;
        int          s;
        int          nbeats;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        cmd_size      = SW'(size);
        cmd_mode      = mode;
        cmd_seed      = seed;
        cmd_d_mac     = r1[47:0];
        cmd_s_mac     = r2[47:0];
        cmd_ethertype = r2[63:48];
        cmd_valid     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", ok, 1'b1);
        if (ok) begin
            s      = (size < MINS) ? MINS : size;
            nbeats = (s + NB - 1) / NB;
            for (int b = 0; b < nbeats; b++) begin
                e.data = model_beat(r1[47:0], r2[47:0], r2[63:48], seed, mode, b);
                e.keep = model_keep(s, b);
                e.last = (b == nbeats - 1);
                exp_q.push_back(e);
            end
            n_sent++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !m_axis_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_drain"}, ok, 1'b1);
        check({tag, "_frames"}, frames_sent, n_sent);
    endtask

    initial begin
        int  base_n;
        bit  found;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_size      = '0;
        cmd_d_mac     = '0;
        cmd_s_mac     = '0;
        cmd_ethertype = '0;
        cmd_seed      = '0;
        cmd_mode      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tkeep", m_axis_tkeep, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_frames", frames_sent, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        send_cmd(64, 1'b0, 8'hAA);
        check("busy_frame", busy, 1'b1);
        drain("fill64");
        check("busy_done", busy, 1'b0);
        check("fill64_b0_pay", cap_data[0][127:112], 16'hAAAA);
        check("fill64_b3_pay", cap_data[3][127:120], 8'hAA);
        check("fill64_keep3", cap_keep[3], 16'hFFFF);

        send_cmd(20, 1'b0, 8'h11);
        drain("pad20");
        check("pad20_keep3", cap_keep[3], 16'h0FFF);

        send_cmd(61, 1'b0, 8'h22);
        drain("size61");
        check("size61_keep3", cap_keep[3], 16'h1FFF);

        send_cmd(64, 1'b1, 8'hFE);
        drain("incr64");
        check("incr_b14", cap_data[0][119:112], 8'hFE);
        check("incr_b15", cap_data[0][127:120], 8'hFF);
        check("incr_b16", cap_data[1][7:0], 8'h00);
        check("incr_b63", cap_data[3][127:120], 8'h2F);

        send_cmd(0, 1'b0, 8'h33);
        drain("size0");
        check("size0_keep3", cap_keep[3], 16'h0FFF);

        send_cmd(80, 1'b1, 8'h40);
        drain("size80");
        check("size80_keep4", cap_keep[4], 16'hFFFF);

        send_cmd(64, 1'b0, 8'h5A);
        send_cmd(33, 1'b1, 8'h07);
        drain("b2b");
        check("b2b_gap", head_gap, 1);

        base_n     = n_sent;
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            send_cmd($urandom_range(0, 100), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        drain("random");
        rand_ready = 1'b0;
        check("random_count", frames_sent, base_n + 100);

        @(posedge clk);
        #1;
        send_cmd(64, 1'b0, 8'h55);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_axis_tvalid && beat_idx == 2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("reach_beat2", found, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_tvalid", m_axis_tvalid, 1'b0);
        check("async_tdata", m_axis_tdata, '0);
        check("async_frames", frames_sent, 32'd0);
        exp_q.delete();
        n_sent = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        send_cmd(70, 1'b1, 8'h03);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/packet_builder_axis.md
# packet_builder_axis

Parametrised Ethernet frame generator, successor to the fixed-width command-driven builder. It takes frame commands over a valid/ready interface and emits complete frames on an AXI4-Stream master with full `tready` backpressure. It supports configurable bus width and size range, minimum-frame padding, two payload modes and a sent-frame counter. It sits between the command FIFO and the MAC TX path of the traffic generator.

## Interface
- `DATA_WIDTH`, 512: AXIS data width in bits; power of two, ≥128 (Ethernet header fits in beat 0).
- `SIZE_WIDTH`, 14: width of the frame-size field; maximum frame size is 2^SIZE_WIDTH−1 bytes.
- `MIN_SIZE`, 60: minimum frame size in bytes; smaller requests are padded.
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous active-low reset. The block has one clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_size`  in  SIZE_WIDTH  frame length in bytes, excluding FCS.
- `cmd_d_mac`, `cmd_s_mac`  in  48  MAC addresses.
- `cmd_ethertype`  in  16  EtherType field.
- `cmd_seed`  in  8  fill byte (mode 0) or start byte (mode 1).
- `cmd_mode`  in  1  payload mode: 0 = constant fill, 1 = incrementing byte.
- `m_axis_tdata`  out  DATA_WIDTH  frame data; byte 0 in bits [7:0].
- `m_axis_tkeep`  out  DATA_WIDTH/8  byte enables.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of the frame.
- `busy`  out  1  a frame is loaded and not yet fully accepted.
- `frames_sent`  out  32  count of frames whose last beat was accepted; wraps.

## Operation
- N = DATA_WIDTH/8. Effective size: S = max(cmd_size, MIN_SIZE), latched at accept. Beats per frame = ceil(S/N).
- Beat 0 layout:
  - bytes 0–5 carry `d_mac`, with `d_mac[7:0]` in byte 0. This matches the existing `tdata[47:0] <= d_mac` mapping.
  - bytes 6–11 carry `s_mac` and bytes 12–13 carry `ethertype`, with the same little-endian field mapping.
  - bytes 14..N−1 are payload.
- Payload byte at frame offset k ≥ 14:
  - mode 0: equals `seed`.
  - mode 1: equals (seed + k − 14) mod 256, continuous across beats.
- `tkeep` is all ones except on the last beat, where the low (S − beat_offset) bits are set and the rest are 0. Bytes outside `tkeep` are don't-care but driven with the payload pattern.
- State machine:
  - IDLE: `cmd_ready`=1. An accepted command moves to HEAD.
  - HEAD: presents beat 0. On acceptance, go to BODY if more beats remain, otherwise finish.
  - BODY: presents payload beats. On acceptance of the last beat, finish.
  - Finish: if a command is accepted in the same cycle, go to HEAD; otherwise go to IDLE.
- `cmd_ready` = (state==IDLE) | (`tvalid` & `tready` & `tlast`). This gives back-to-back frames with no idle cycle.
- Backpressure: while `tvalid` & !`tready`, the `tdata`, `tkeep` and `tlast` outputs and all internal counters hold.
- `frames_sent` increments on every `tvalid & tready & tlast`.
- Reset mid-frame: the frame is abandoned immediately and no partial continuation follows.

## Timing
- Reset values: `m_axis_tvalid`=0, `tlast`=0, `tdata`=0, `tkeep`=0, `busy`=0, `frames_sent`=0, state IDLE. `cmd_ready` is 1 once `rst_n` is high.
- Command accepted at edge t → beat 0 is valid from t+1. All outputs are registered.
- With `tready` held at 1, a frame occupies exactly ceil(S/N) consecutive cycles. The next frame's beat 0 follows in the cycle directly after `tlast`.
- `busy` is 1 from t+1 until the cycle after the last beat is accepted, unless a new command is chained.
- `cmd_size`=0 is padded to MIN_SIZE like any other short request.
- `cmd_size` > N that lands exactly on a beat boundary produces a full `tkeep` on the last beat.

## Structure
- Package `packet_builder_pkg`: constants `ETH_HDR_BYTES`=14, `MODE_FILL`=0, `MODE_INCR`=1, and the command-field widths.
- Sub-module `axis_keep_mask` (combinational): converts the remaining byte count into a `tkeep` vector. It is reused by the future RX checker.
- The top level holds the state machine, the output register, the payload-byte generator and the counters.

## Test plan
All scenarios use DATA_WIDTH=128, so N=16.
- Size 64, mode 0, seed 0xAA, `tready`=1 → 4 beats with `tkeep`=0xFFFF and `tlast` on beat 3. Bytes 14..63 are 0xAA and `frames_sent`=1.
- Size 20 → padded to 60: 4 beats, last `tkeep`=0x0FFF.
- Size 61 → 4 beats, last `tkeep`=0x1FFF.
- Mode 1, seed 0xFE, size 64 → bytes 14 and 15 are 0xFE and 0xFF, byte 16 is 0x00, and byte 63 is 0x2F.
- Two commands queued, `tready`=1 → the second frame's beat 0 directly follows the first frame's `tlast` with no gap. `cmd_ready` pulses on that `tlast` cycle.
- Random `tready` toggling at 50% over 100 frames → the output stream matches the reference model byte-for-byte, outputs are stable while stalled, and `frames_sent`=100.
- `rst_n` asserted on beat 2 of a 4-beat frame → `tvalid` drops without waiting for a clock. After release the block is in IDLE and the next command yields a clean frame.
